stream_avg_ctrl: RTL and testbench
==================================

# stream_avg_ctrl

Window-averaging controller and initiator for the team's iterative unsigned divider (start/busy/done handshake). It accepts a stream of unsigned samples and sums a window of `win_len` samples. It then issues one divide request (sum / count) to the divider, captures the quotient and remainder, and presents the average on a valid/ready output. It sits between the sample input stage and the averaged-output consumer of the streaming average unit.

## Interface
- `WIDTH`, 5: sample, sum and divider operand width in bits; must match the divider's `WIDTH`.
- `WIN_MAX`, 4: maximum window length. `CNT_W = $clog2(WIN_MAX+1)`.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous and active-high. Single clock domain.
- `in_valid` in 1, `in_ready` out 1, `in_data` in WIDTH: sample stream.
- `win_len` in CNT_W: window length. Sampled when the first sample of a window is accepted.
- `flush` in 1: single-cycle pulse that closes the current window early.
- `div_start` out 1, `div_a` out WIDTH, `div_b` out WIDTH: divider request.
- `div_busy` in 1, `div_done` in 1, `div_valid` in 1, `div_dbz` in 1, `div_val` in WIDTH, `div_rem` in WIDTH: divider response.
- `avg_valid` out 1, `avg_ready` in 1: result handshake.
- `avg_data` out WIDTH, `avg_rem` out WIDTH: average and remainder.
- `avg_dbz` out 1: the window was empty.
- `avg_sat` out 1: the sum saturated.

## Operation
- FSM states: `ACCUM`, `ISSUE`, `WAIT`, `OUT`. Reset state is `ACCUM`.
- **ACCUM**
  - `in_ready = 1`.
  - On each `in_valid && in_ready`: add `in_data` to the sum and increment the count.
  - The sum saturates at 2^WIDTH-1 and sets the sticky `sat` flag.
  - The latched length is `min(win_len, WIN_MAX)`. A latched length of 0 means the window is closed by `flush` only.
  - Window closes when the count reaches the latched length, or on `flush`. Go to `ISSUE`.
  - A sample and `flush` in the same cycle: the sample is included, then the window closes.
  - `flush` with count 0 closes an empty window. This goes to `ISSUE` with `b = 0`.
- **ISSUE**
  - `in_ready = 0`.
  - Assert `div_start` for exactly one cycle, with `div_a = sum` and `div_b = count` zero-extended.
  - If `div_busy = 1`, hold in `ISSUE` with `div_start = 0` until `div_busy` drops.
  - Then go to `WAIT`.
- **WAIT**
  - On `div_done`: capture `div_val`, `div_rem`, `div_dbz` and `sat` into the output registers, then go to `OUT`.
  - On `div_dbz`: `avg_data = 0` and `avg_rem = 0`.
- **OUT**
  - `avg_valid = 1`; all `avg_*` outputs are held stable.
  - On `avg_ready`: clear sum, count and `sat`, and return to `ACCUM`.
- `div_done` is ignored in every state except `WAIT`.
- `div_a` and `div_b` are driven only in `ISSUE`; they are 0 otherwise.

## Timing
- All outputs are registered. Reset value of every output is 0 (`in_ready` is 1 after reset, since the reset state is `ACCUM`).
- Last sample accepted in cycle T:
  - `div_start` is high in T+1.
  - The divider raises `div_done` in T+2+WIDTH.
  - `avg_valid` rises in T+3+WIDTH (cycle 8 for WIDTH=5).
- Empty window (`flush` at T): `div_start` in T+1, `div_done` (dbz) in T+2, `avg_valid` in T+3.
- Throughput: one average per window. `in_ready = 0` from `ISSUE` through the `avg_ready` handshake.
- Reset during `WAIT` or `OUT`:
  - All state clears immediately.
  - A later stray `div_done` is ignored, because the FSM is in `ACCUM`.

## Configuration
- `STREAM_AVG_ROUND_EN`
  - Defined: the quotient is rounded half-up. If `2*div_rem >= count`, then `avg_data = div_val + 1`, saturating at 2^WIDTH-1. `avg_rem` still reports the raw `div_rem`. This adds no extra cycles; rounding is computed at capture in `WAIT`.
  - Undefined: `avg_data = div_val` (truncation).

## Structure
- Package `stream_avg_pkg` holds:
  - the FSM state enum `avg_state_e`;
  - the `WIDTH` and `WIN_MAX` defaults;
  - `CNT_W`.
- One sub-module: `stream_avg_acc` (saturating sum, count, window-length latch and `sat` flag).
- The divider is instantiated alongside the controller at the top level, not inside it.

## Test plan
1. WIDTH=5, `win_len = 4`, samples 3, 5, 7, 9 -> `div_a = 24`, `div_b = 4`; `avg_data = 6`, `avg_rem = 0`; `avg_valid` 8 cycles after the last sample.
2. `win_len = 3`, samples 1, 2, 2 -> `avg_data = 1`, `avg_rem = 2`. With `STREAM_AVG_ROUND_EN` defined -> `avg_data = 2`.
3. `flush` with no samples -> `div_b = 0`; `avg_dbz = 1`, `avg_data = 0`; `avg_valid` 3 cycles after `flush`.
4. `win_len = 4`, samples 31, 31, 1, 1 -> sum saturates at 31, `avg_sat = 1`; `avg_data = 7`, `avg_rem = 3`.
5. Hold `avg_ready = 0` for 10 cycles after `avg_valid` -> outputs stable, `in_ready = 0`, no `div_start`. Then `avg_ready = 1` -> `in_ready = 1` next cycle.
6. Assert `rst` mid-`WAIT`, then inject `div_done` -> all outputs 0, state `ACCUM`, no `avg_valid`.

Source files
------------

// File: rtl/stream_avg_pkg.sv
// stream_avg_pkg
// Shared definitions for the streaming window-average controller:
//   - default sample/sum width and maximum window length
//   - width of the sample counter / window-length field
//   - controller state enum (also exported on the debug state port)
package stream_avg_pkg;

    localparam int WIDTH_DEF   = 5;
    localparam int WIN_MAX_DEF = 4;
    localparam int CNT_W_DEF   = $clog2(WIN_MAX_DEF + 1);

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } avg_state_e;

endpackage

// File: rtl/stream_avg_acc.sv
// stream_avg_acc
// Window accumulator: saturating sum, sample count, window-length latch and
// sticky saturation flag.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   accept        a sample is taken this cycle
//   flush         close the current window this cycle (already gated to ACCUM)
//   clear         drop the finished window (result handed off)
//   in_data       sample value
//   win_len       requested window length, latched on the first sample
//   sum_nxt       sum including this cycle's sample (next register value)
//   cnt_nxt       count including this cycle's sample (next register value)
//   sat           sticky: the sum has clipped at all-ones
//   close         the window ends this cycle
import stream_avg_pkg::*;

module stream_avg_acc #(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int WIN_MAX = WIN_MAX_DEF,
    parameter int CNT_W   = $clog2(WIN_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept,
    input  logic             flush,
    input  logic             clear,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] win_len,
    output logic [WIDTH-1:0] sum_nxt,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic             sat,
    output logic             close
);

    localparam logic [CNT_W-1:0] LEN_CAP = CNT_W'(WIN_MAX);
    localparam logic [CNT_W-1:0] CNT_ALL = '1;

    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] len_nxt;
    logic [CNT_W-1:0] cap_len;
    logic [CNT_W-1:0] len_eff;
    logic             sat_nxt;
    logic [WIDTH:0]   sum_ext;

    assign cap_len = (win_len > LEN_CAP) ? LEN_CAP : win_len;
    // Before the first sample the live win_len applies; afterwards the latch.
    assign len_eff = (cnt_q == '0) ? cap_len : len_q;
    assign sum_ext = {1'b0, sum_q} + {1'b0, in_data};

    always_comb begin
        sum_nxt = sum_q;
        cnt_nxt = cnt_q;
        sat_nxt = sat;
        len_nxt = len_q;
        if (clear) begin
            sum_nxt = '0;
            cnt_nxt = '0;
            sat_nxt = 1'b0;
            len_nxt = '0;
        end else if (accept) begin
            sum_nxt = sum_ext[WIDTH] ? '1 : sum_ext[WIDTH-1:0];
            sat_nxt = sat | sum_ext[WIDTH];
            // A flush-only window (length 0) can outrun the counter; hold it
            // at all-ones instead of wrapping back to an empty window.
            if (cnt_q != CNT_ALL) begin
                cnt_nxt = cnt_q + 1'b1;
            end
            if (cnt_q == '0) begin
                len_nxt = cap_len;
            end
        end
    end

    assign close = flush || (accept && (len_eff != '0) && (cnt_nxt == len_eff));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            cnt_q <= '0;
            len_q <= '0;
            sat   <= 1'b0;
        end else begin
            sum_q <= sum_nxt;
            cnt_q <= cnt_nxt;
            len_q <= len_nxt;
            sat   <= sat_nxt;
        end
    end

endmodule

// File: rtl/stream_avg_ctrl.sv
// stream_avg_ctrl
// Window-averaging controller: sums a window of samples, issues one divide
// request (sum / count) to an external iterative divider and presents the
// quotient and remainder on a valid/ready output.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid, once raised, holds its data stable until that edge.
// The divider side is start/busy/done: div_start is a one-cycle pulse issued
// only while div_busy is low, and div_done marks a one-cycle result strobe.
//
// Configuration macro: STREAM_AVG_ROUND_EN -- when defined the quotient is
// rounded half-up (saturating); otherwise it is truncated.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_ready/in_data     sample stream
//   win_len                       window length (0 = flush-closed only)
//   flush                         close current window early
//   div_start/div_a/div_b         divider request
//   div_busy/div_done/div_valid/
//   div_dbz/div_val/div_rem       divider response
//   avg_valid/avg_ready           result handshake
//   avg_data/avg_rem              average and remainder
//   avg_dbz                       the window was empty
//   avg_sat                       the window sum clipped
//   dbg_state                     current controller state
import stream_avg_pkg::*;

module stream_avg_ctrl #(
    parameter  int WIDTH   = WIDTH_DEF,
    parameter  int WIN_MAX = WIN_MAX_DEF,
    localparam int CNT_W   = $clog2(WIN_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] win_len,
    input  logic             flush,
    output logic             div_start,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic             div_busy,
    input  logic             div_done,
    input  logic             div_valid,
    input  logic             div_dbz,
    input  logic [WIDTH-1:0] div_val,
    input  logic [WIDTH-1:0] div_rem,
    output logic             avg_valid,
    input  logic             avg_ready,
    output logic [WIDTH-1:0] avg_data,
    output logic [WIDTH-1:0] avg_rem,
    output logic             avg_dbz,
    output logic             avg_sat,
    output avg_state_e       dbg_state
);

    avg_state_e       state;
    avg_state_e       state_n;
    logic             start_n;
    logic             accept;
    logic             flush_acc;
    logic             clear;
    logic             close;
    logic             sat;
    logic             resp_dbz;
    logic             capture;
    logic [WIDTH-1:0] sum_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [WIDTH-1:0] q_adj;

    assign accept    = (state == ACCUM) && in_valid;
    assign flush_acc = (state == ACCUM) && flush;
    assign clear     = (state == OUT) && avg_ready;
    assign capture   = (state == WAIT) && div_done;
    // A done without a valid result is reported like a divide-by-zero.
    assign resp_dbz  = div_dbz || !div_valid;
    assign dbg_state = state;

    stream_avg_acc #(
        .WIDTH   (WIDTH),
        .WIN_MAX (WIN_MAX),
        .CNT_W   (CNT_W)
    ) u_acc (
        .clk     (clk),
        .rst     (rst),
        .accept  (accept),
        .flush   (flush_acc),
        .clear   (clear),
        .in_data (in_data),
        .win_len (win_len),
        .sum_nxt (sum_nxt),
        .cnt_nxt (cnt_nxt),
        .sat     (sat),
        .close   (close)
    );

`ifdef STREAM_AVG_ROUND_EN
    logic [WIDTH:0] rem_x2;
    logic           round_up;
    // The count is stable while waiting on the divider, so the live count
    // is the divisor the divider is working on.
    assign rem_x2   = {div_rem, 1'b0};
    assign round_up = rem_x2 >= (WIDTH+1)'(cnt_nxt);
    assign q_adj    = (round_up && (div_val != '1)) ? div_val + 1'b1 : div_val;
`else
    assign q_adj    = div_val;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        start_n = 1'b0;
        case (state)
            ACCUM: begin
                if (close) begin
                    state_n = ISSUE;
                    start_n = !div_busy;
                end
            end
            ISSUE: begin
                // div_start high now means the request went out this cycle.
                if (div_start) begin
                    state_n = WAIT;
                end else begin
                    start_n = !div_busy;
                end
            end
            WAIT: begin
                if (div_done) begin
                    state_n = OUT;
                end
            end
            OUT: begin
                if (avg_ready) begin
                    state_n = ACCUM;
                end
            end
            default: state_n = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            div_start <= 1'b0;
            div_a     <= '0;
            div_b     <= '0;
            avg_valid <= 1'b0;
            avg_data  <= '0;
            avg_rem   <= '0;
            avg_dbz   <= 1'b0;
            avg_sat   <= 1'b0;
        end else begin
            in_ready  <= (state_n == ACCUM);
            div_start <= start_n;
            if (state_n == ISSUE) begin
                div_a <= sum_nxt;
                div_b <= WIDTH'(cnt_nxt);
            end else begin
                div_a <= '0;
                div_b <= '0;
            end
            if (capture) begin
                avg_valid <= 1'b1;
                avg_data  <= resp_dbz ? '0 : q_adj;
                avg_rem   <= resp_dbz ? '0 : div_rem;
                avg_dbz   <= resp_dbz;
                avg_sat   <= sat;
            end else if (clear) begin
                avg_valid <= 1'b0;
                avg_data  <= '0;
                avg_rem   <= '0;
                avg_dbz   <= 1'b0;
                avg_sat   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_avg_ctrl.sv
// tb_stream_avg_ctrl
// Bench for stream_avg_ctrl with a behavioural iterative divider attached.
// Expected results come from plain arithmetic over each window's samples.
import stream_avg_pkg::*;

module tb_stream_avg_ctrl;

    localparam int W  = WIDTH_DEF;
    localparam int WM = WIN_MAX_DEF;
    localparam int CW = CNT_W_DEF;
    localparam int MAXV = (1 << W) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data  = '0;
    logic [CW-1:0] win_len  = '0;
    logic          flush    = 1'b0;
    logic          div_start;
    logic [W-1:0]  div_a;
    logic [W-1:0]  div_b;
    logic          div_busy;
    logic          div_done;
    logic          div_valid;
    logic          div_dbz;
    logic [W-1:0]  div_val;
    logic [W-1:0]  div_rem;
    logic          avg_valid;
    logic          avg_ready = 1'b0;
    logic [W-1:0]  avg_data;
    logic [W-1:0]  avg_rem;
    logic          avg_dbz;
    logic          avg_sat;
    avg_state_e    dbg_state;

    logic busy_force  = 1'b0;
    logic inject_done = 1'b0;

    stream_avg_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .win_len   (win_len),
        .flush     (flush),
        .div_start (div_start),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_busy  (div_busy),
        .div_done  (div_done),
        .div_valid (div_valid),
        .div_dbz   (div_dbz),
        .div_val   (div_val),
        .div_rem   (div_rem),
        .avg_valid (avg_valid),
        .avg_ready (avg_ready),
        .avg_data  (avg_data),
        .avg_rem   (avg_rem),
        .avg_dbz   (avg_dbz),
        .avg_sat   (avg_sat),
        .dbg_state (dbg_state)
    );

    // ---------------- divider model ----------------
    // Start seen at edge E: done high WIDTH cycles later, or one cycle later
    // for a zero divisor. Not reset, so it can deliver a stray done.
    logic         m_busy  = 1'b0;
    logic         m_done  = 1'b0;
    logic         m_valid = 1'b0;
    logic         m_dbz   = 1'b0;
    logic [W-1:0] m_q     = '0;
    logic [W-1:0] m_r     = '0;
    int           m_left  = 0;

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (m_left > 0) begin
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_busy <= 1'b0;
            end
            m_left <= m_left - 1;
        end else if (div_start) begin
            if (div_b == '0) begin
                m_done  <= 1'b1;
                m_dbz   <= 1'b1;
                m_valid <= 1'b0;
                m_q     <= '1;
                m_r     <= div_a;
            end else begin
                m_busy  <= 1'b1;
                m_left  <= W;
                m_dbz   <= 1'b0;
                m_valid <= 1'b1;
                m_q     <= div_a / div_b;
                m_r     <= div_a % div_b;
            end
        end
    end

    assign div_busy  = m_busy | busy_force;
    assign div_done  = m_done | inject_done;
    assign div_valid = m_valid;
    assign div_dbz   = m_dbz;
    assign div_val   = m_q;
    assign div_rem   = m_r;

    // ---------------- scoreboard ----------------
    int           n_checks = 0;
    int           n_errors = 0;
    logic [W-1:0] exp_q[$];
    bit           exp_f[$];
    int           smp[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int eff_len(input int wl);
        return (wl > WM) ? WM : wl;
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge of the cycle after the
    // window closed. t_last is the cycle of the closing sample or flush.
    task automatic drive_samples(input int wl, input int fmode, output int t_last);
        in_valid = 1'b0;
        flush    = 1'b0;
        win_len  = CW'(wl);
        t_last   = cyc;
        foreach (smp[i]) begin
            if (i > 0) begin
                // win_len is latched on the first sample; disturb it afterwards
                win_len = CW'($urandom_range(0, 7));
                if ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    flush    = 1'b0;
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_data  = W'(smp[i]);
            flush    = (fmode == 1) && (i == smp.size() - 1);
            t_last   = cyc;
            @(negedge clk);
        end
        if (fmode == 2) begin
            in_valid = 1'b0;
            flush    = 1'b1;
            t_last   = cyc;
            @(negedge clk);
        end
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    // fmode: 0 = closes on count, 1 = flush with last sample, 2 = flush after
    task automatic run_window(input int wl, input int fmode, input int hold, input int busy_cyc);
        int sum, s, n, q, r, t_last, lat, k;
        logic [W-1:0] e_data, e_rem;
        bit e_dbz, e_sat;
        sum = 0;
        foreach (smp[i]) sum += smp[i];
        n = smp.size();
        s = (sum > MAXV) ? MAXV : sum;
        if (n == 0) begin
            q = 0;
            r = 0;
        end else begin
            q = s / n;
            r = s % n;
`ifdef STREAM_AVG_ROUND_EN
            if (2 * r >= n && q < MAXV) q = q + 1;
`endif
        end
        exp_q.push_back(W'(q));
        exp_q.push_back(W'(r));
        exp_f.push_back(n == 0);
        exp_f.push_back(sum > MAXV);

        busy_force = (busy_cyc > 0);
        drive_samples(wl, fmode, t_last);
        for (int b = 0; b < busy_cyc; b++) begin
            check("start_held_busy", div_start, 0);
            check("in_ready_issue", in_ready, 0);
            if (b == busy_cyc - 1) busy_force = 1'b0;
            @(negedge clk);
        end
        check("div_start", div_start, 1);
        check("div_a", div_a, s);
        check("div_b", div_b, n);
        check("in_ready_closed", in_ready, 0);

        k = 0;
        while (!avg_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("avg_valid_seen", avg_valid, 1);
        lat = cyc - t_last;
        check("avg_latency", lat, ((n == 0) ? 3 : 8) + busy_cyc);

        e_data = exp_q.pop_front();
        e_rem  = exp_q.pop_front();
        e_dbz  = exp_f.pop_front();
        e_sat  = exp_f.pop_front();
        check("avg_data", avg_data, e_data);
        check("avg_rem", avg_rem, e_rem);
        check("avg_dbz", avg_dbz, e_dbz);
        check("avg_sat", avg_sat, e_sat);

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", avg_valid, 1);
            check("hold_data", avg_data, e_data);
            check("hold_rem", avg_rem, e_rem);
            check("hold_in_ready", in_ready, 0);
            check("hold_no_start", div_start, 0);
        end
        avg_ready = 1'b1;
        @(negedge clk);
        avg_ready = 1'b0;
        check("in_ready_after", in_ready, 1);
        check("avg_valid_after", avg_valid, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t, wl, e, fmode, n;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_div_start", div_start, 0);
        check("rst_avg_valid", avg_valid, 0);
        check("rst_state", dbg_state, ACCUM);
        rst = 1'b0;
        @(negedge clk);

        // directed windows
        smp = '{3, 5, 7, 9};    run_window(4, 0, 0, 0);
        smp = '{1, 2, 2};       run_window(3, 0, 0, 0);
        smp = {};               run_window(4, 2, 0, 0);
        smp = '{31, 31, 1, 1};  run_window(4, 0, 0, 0);
        smp = '{10, 20};        run_window(2, 0, 10, 0);
        smp = '{9};             run_window(1, 0, 0, 3);
        smp = '{1, 1, 1, 1};    run_window(6, 0, 0, 0);
        smp = '{6, 4};          run_window(0, 1, 0, 0);

        // reset while waiting on the divider, then a stray done
        smp = '{4, 4};
        drive_samples(2, 0, t);
        @(negedge clk);
        check("state_wait", dbg_state, WAIT);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_div_start", div_start, 0);
        check("mid_rst_div_a", div_a, 0);
        check("mid_rst_div_b", div_b, 0);
        check("mid_rst_avg_valid", avg_valid, 0);
        check("mid_rst_avg_data", avg_data, 0);
        check("mid_rst_avg_rem", avg_rem, 0);
        check("mid_rst_avg_dbz", avg_dbz, 0);
        check("mid_rst_avg_sat", avg_sat, 0);
        check("mid_rst_state", dbg_state, ACCUM);
        @(negedge clk);
        rst = 1'b0;
        inject_done = 1'b1;
        @(negedge clk);
        inject_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("stray_no_valid", avg_valid, 0);
            check("stray_state", dbg_state, ACCUM);
            check("stray_no_start", div_start, 0);
            @(negedge clk);
        end

        // randomized windows
        for (int it = 0; it < 30; it++) begin
            wl = $urandom_range(0, 7);
            e  = eff_len(wl);
            fmode = (e == 0) ? $urandom_range(1, 2) : $urandom_range(0, 2);
            case (fmode)
                0:       n = e;
                1:       n = $urandom_range(1, (e == 0) ? 3 : e);
                default: n = $urandom_range(0, (e == 0) ? 3 : e - 1);
            endcase
            smp = {};
            for (int j = 0; j < n; j++) begin
                smp.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(24, 31)
                                                          : $urandom_range(0, 31));
            end
            run_window(wl, fmode, $urandom_range(0, 3), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
